// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter and the arbiter in front of it.
package uart_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } uart_arb_state_t;

    localparam int unsigned CLK_FREQ_HZ  = 50_000_000;
    localparam int unsigned BAUD_RATE    = 115_200;
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request strictly after last_idx, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               found,
    output logic [IDX_W-1:0]   next_idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        found    = 1'b0;
        next_idx = last_idx;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand     = (32'(last_idx) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found    = 1'b1;
                next_idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter among several byte streams.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned STALL_TIMEOUT = 25_000_000,
    parameter int unsigned GRANT_W       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_have_new_data,
    output logic [7:0]           tx_new_data,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 abort_pulse
);

    localparam int unsigned CNT_W = (STALL_TIMEOUT == 0) ? 1 : $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    uart_arb_state_t    state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic               hold_valid_q, hold_valid_d;
    logic [7:0]         hold_data_q, hold_data_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               abort_q, abort_d;

    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;
    logic               gnt_valid, gnt_last, slot_free, xfer, stall, timeout_hit;
    logic [7:0]         gnt_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GRANT_W)
    ) u_picker (
        .req      (req_valid),
        .last_idx (grant_q),
        .found    (pick_found),
        .next_idx (pick_idx)
    );

    always_comb begin
        gnt_valid   = req_valid[grant_q];
        gnt_last    = req_last[grant_q];
        gnt_data    = req_data[{grant_q, 3'b000} +: 8];
        slot_free   = !hold_valid_q || tx_ready;
        xfer        = (state_q == LOCKED) && gnt_valid && slot_free;
        stall       = (state_q == LOCKED) && !gnt_valid;
        timeout_hit = 1'b0;
        // Fires on the stall cycle whose count reaches STALL_TIMEOUT-1, so the pulse is
        // visible STALL_TIMEOUT cycles after the last transfer.
        if (STALL_TIMEOUT != 0) begin
            timeout_hit = stall && (int'(stall_cnt_q) + 1 >= int'(STALL_TIMEOUT) - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (pick_found) state_d = LOCKED;
            LOCKED: if ((xfer && gnt_last) || timeout_hit) state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == LOCKED) begin
            req_ready[grant_q] = slot_free;
        end
        busy             = (state_q == LOCKED);
        grant_id         = grant_q;
        tx_have_new_data = hold_valid_q;
        tx_new_data      = hold_data_q;
        abort_pulse      = abort_q;
    end

    always_comb begin
        grant_d      = grant_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        stall_cnt_d  = stall_cnt_q;
        abort_d      = timeout_hit;

        if (state_q == IDLE && pick_found) begin
            grant_d = pick_idx;
        end

        // A load in the same cycle as a drain keeps the register full.
        if (xfer) begin
            hold_valid_d = 1'b1;
            hold_data_d  = gnt_data;
        end else if (hold_valid_q && tx_ready) begin
            hold_valid_d = 1'b0;
        end

        if (state_q == IDLE || xfer) begin
            stall_cnt_d = '0;
        end else if (stall && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= GRANT_W'(NUM_REQ - 1);
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
            stall_cnt_q  <= '0;
            abort_q      <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            stall_cnt_q  <= stall_cnt_d;
            abort_q      <= abort_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenario bench for uart_tx_arbiter with a simple frame-delay transmitter model.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int TO    = 16;
    localparam int FRAME = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           tx_have_new_data;
    logic [7:0]     tx_new_data;
    logic           tx_ready;
    logic           busy;
    logic [1:0]     grant_id;
    logic           abort_pulse;

    logic tx_rdy_m  = 1'b1;
    logic tx_block  = 1'b0;
    logic tx_stream = 1'b0;
    assign tx_ready = tx_rdy_m & ~tx_block;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    int         acc_id[$];
    logic [7:0] acc_data[$];
    int         acc_cyc[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .tx_have_new_data (tx_have_new_data),
        .tx_new_data      (tx_new_data),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .grant_id         (grant_id),
        .abort_pulse      (abort_pulse)
    );

    // Requester-side accept log
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_id.push_back(i);
                    acc_data.push_back(req_data[i*8 +: 8]);
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    // Transmitter model: drops ready for FRAME cycles after each accept unless streaming
    initial forever begin
        @(negedge clk);
        if (rst_n && tx_have_new_data && tx_ready) begin
            tx_log.push_back(tx_new_data);
            tx_cyc.push_back(cyc);
            if (!tx_stream) begin
                @(posedge clk);
                #1 tx_rdy_m = 1'b0;
                repeat (FRAME) @(posedge clk);
                #1 tx_rdy_m = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        acc_id.delete();
        acc_data.delete();
        acc_cyc.delete();
        tx_log.delete();
        tx_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    task automatic send_pkt(input int r, input int n, input logic [7:0] base);
        int w;
        for (int i = 0; i < n; i++) begin
            req_valid[r]       = 1'b1;
            req_data[r*8 +: 8] = base + 8'(i);
            req_last[r]        = (i == n - 1);
            w = 0;
            @(negedge clk);
            while (!req_ready[r] && w < 500) begin
                w++;
                @(negedge clk);
            end
            checks++;
            if (!req_ready[r]) begin
                fails++;
                $display("FAIL send_ready: req %0d ready=%b, required 1 within 500 cycles",
                         r, req_ready[r]);
            end
            @(posedge clk);
            #1;
        end
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    task automatic wait_tx(input int cnt);
        int w = 0;
        while (tx_log.size() < cnt && w < 500) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin fails++;
            $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
        checks++; if (tx_have_new_data !== 1'b0) begin fails++;
            $display("FAIL reset_have: got %b required 0", tx_have_new_data); end
        checks++; if (tx_new_data !== 8'h00) begin fails++;
            $display("FAIL reset_data: got %h required 00", tx_new_data); end
        checks++; if (busy !== 1'b0) begin fails++;
            $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (grant_id !== 2'd3) begin fails++;
            $display("FAIL reset_grant: got %0d required 3", grant_id); end
        checks++; if (abort_pulse !== 1'b0) begin fails++;
            $display("FAIL reset_abort: got %b required 0", abort_pulse); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        do_reset();
        send_pkt(0, 3, 8'h41);
        checks++; if (busy !== 1'b0) begin fails++;
            $display("FAIL single_busy_after_last: got %b required 0", busy); end
        checks++; if (grant_id !== 2'd0) begin fails++;
            $display("FAIL single_grant: got %0d required 0", grant_id); end
        wait_tx(3);
        checks++; if (tx_log.size() != 3) begin fails++;
            $display("FAIL single_count: got %0d bytes required 3", tx_log.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= tx_log.size() || tx_log[i] !== exp[i]) begin fails++;
                $display("FAIL single_byte%0d: got %h required %h", i,
                         (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp[i]); end
        end
    endtask

    task automatic test_two();
        int         exp_id [8] = '{1, 1, 2, 2, 1, 1, 2, 2};
        logic [7:0] exp_b  [8] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41};
        do_reset();
        fork
            send_pkt(1, 2, 8'h10);
            send_pkt(2, 2, 8'h20);
        join
        fork
            send_pkt(1, 2, 8'h30);
            send_pkt(2, 2, 8'h40);
        join
        wait_tx(8);
        checks++; if (acc_id.size() != 8 || tx_log.size() != 8) begin fails++;
            $display("FAIL two_count: got %0d accepts %0d tx, required 8 and 8",
                     acc_id.size(), tx_log.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= acc_id.size() || acc_id[i] != exp_id[i]) begin fails++;
                $display("FAIL two_order%0d: got id %0d required %0d", i,
                         (i < acc_id.size()) ? acc_id[i] : -1, exp_id[i]); end
            checks++;
            if (i >= tx_log.size() || tx_log[i] !== exp_b[i]) begin fails++;
                $display("FAIL two_byte%0d: got %h required %h", i,
                         (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_b[i]); end
        end
    endtask

    task automatic test_no_starve();
        int exp_id [6] = '{0, 3, 0, 3, 0, 3};
        do_reset();
        fork
            begin
                send_pkt(0, 2, 8'h50);
                send_pkt(0, 2, 8'h52);
                send_pkt(0, 2, 8'h54);
            end
            begin
                send_pkt(3, 2, 8'h60);
                send_pkt(3, 2, 8'h62);
                send_pkt(3, 2, 8'h64);
            end
        join
        wait_tx(12);
        checks++; if (acc_id.size() != 12 || tx_log.size() != 12) begin fails++;
            $display("FAIL starve_count: got %0d accepts %0d tx, required 12 and 12",
                     acc_id.size(), tx_log.size()); end
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (2 * p + 1 >= acc_id.size() || acc_id[2*p] != exp_id[p]
                || acc_id[2*p+1] != exp_id[p]) begin fails++;
                $display("FAIL starve_pkt%0d: got ids %0d,%0d required %0d", p,
                         (2 * p + 1 < acc_id.size()) ? acc_id[2*p] : -1,
                         (2 * p + 1 < acc_id.size()) ? acc_id[2*p+1] : -1, exp_id[p]); end
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        req_valid[0]      = 1'b1;
        req_data[7:0]     = 8'h60;
        req_last[0]       = 1'b0;
        req_valid[1]      = 1'b1;
        req_data[15:8]    = 8'h61;
        req_last[1]       = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[0] && n < 50) begin n++; @(negedge clk); end
        checks++; if (req_ready !== 4'b0001) begin fails++;
            $display("FAIL timeout_first_grant: ready %b required 0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!abort_pulse && n < 40);
        checks++; if (n != 16) begin fails++;
            $display("FAIL timeout_latency: abort after %0d cycles required 16", n); end
        checks++; if (busy !== 1'b0) begin fails++;
            $display("FAIL timeout_idle: busy %b required 0", busy); end
        @(negedge clk);
        checks++; if (abort_pulse !== 1'b0) begin fails++;
            $display("FAIL timeout_pulse_width: abort %b required 0", abort_pulse); end
        checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin fails++;
            $display("FAIL timeout_regrant: busy %b grant %0d required 1 and 1",
                     busy, grant_id); end
        checks++; if (req_ready !== 4'b0010) begin fails++;
            $display("FAIL timeout_ready1: ready %b required 0010", req_ready); end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        wait_tx(2);
        checks++; if (tx_log.size() != 2 || tx_log[0] !== 8'h60 || tx_log[1] !== 8'h61)
            begin fails++;
            $display("FAIL timeout_bytes: got %0d bytes first %h, required 60,61",
                     tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 8'hxx); end
    endtask

    task automatic test_stream();
        logic [7:0] exp [4] = '{8'h70, 8'h71, 8'h72, 8'h73};
        do_reset();
        tx_stream = 1'b1;
        send_pkt(0, 4, 8'h70);
        wait_tx(4);
        checks++; if (acc_id.size() != 4 || tx_log.size() != 4) begin fails++;
            $display("FAIL stream_count: got %0d accepts %0d tx, required 4 and 4",
                     acc_id.size(), tx_log.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < acc_cyc.size() && i < tx_log.size()) begin
                checks++;
                if (acc_data[i] !== exp[i] || tx_log[i] !== exp[i]) begin fails++;
                    $display("FAIL stream_byte%0d: accepted %h sent %h required %h", i,
                             acc_data[i], tx_log[i], exp[i]); end
                checks++;
                if (acc_cyc[i] != acc_cyc[0] + i || tx_cyc[i] != acc_cyc[i] + 1) begin
                    fails++;
                    $display("FAIL stream_timing%0d: accept cyc %0d tx cyc %0d, required %0d,%0d",
                             i, acc_cyc[i], tx_cyc[i], acc_cyc[0] + i, acc_cyc[0] + i + 1); end
            end
        end
        tx_stream = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_stream     = 1'b1;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h80;
        req_last[0]   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_have_new_data !== 1'b1 || req_ready[0] !== 1'b1 || busy !== 1'b1)
            begin fails++;
            $display("FAIL midrst_pre: have %b ready %b busy %b required 1,1,1",
                     tx_have_new_data, req_ready[0], busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_have_new_data !== 1'b0) begin fails++;
            $display("FAIL midrst_have: got %b required 0", tx_have_new_data); end
        checks++; if (req_ready !== 4'b0000) begin fails++;
            $display("FAIL midrst_ready: got %b required 0000", req_ready); end
        checks++; if (busy !== 1'b0 || grant_id !== 2'd3) begin fails++;
            $display("FAIL midrst_state: busy %b grant %0d required 0 and 3", busy, grant_id); end
        req_last[0]    = 1'b1;
        req_valid[1]   = 1'b1;
        req_data[15:8] = 8'h90;
        req_last[1]    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin fails++;
            $display("FAIL midrst_priority: busy %b grant %0d required 1 and 0",
                     busy, grant_id); end
        req_valid = '0;
        req_last  = '0;
        tx_stream = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_no_starve();
        test_timeout();
        test_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
